nested_counter: RTL and testbench
=================================

NESTED_COUNTER -- requirements
Module: nested_counter

Interface
REQ-001 Parameter NDIM, default 2: number of nested loop dimensions; dimension 0 is innermost; legal range 1..4.
REQ-002 Parameter WIDTH, default 8: width of each per-dimension index and bound.
REQ-003 Parameter ADDR_W, default 16: width of base, stride and addr.
REQ-004 clock  input  1  single clock; all state changes on posedge clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin a sweep; sampled only in IDLE.
REQ-007 base  input  ADDR_W  start address; latched on accepted start.
REQ-008 bound  input  NDIM x WIDTH  per-dimension iteration count; latched on accepted start.
REQ-009 stride  input  NDIM x ADDR_W  per-dimension address increment; latched on accepted start.
REQ-010 out_ready  input  1  consumer accepts the current beat.
REQ-011 out_valid  output  1  addr/idx hold a valid beat.
REQ-012 addr  output  ADDR_W  current address.
REQ-013 idx  output  NDIM x WIDTH  current per-dimension index.
REQ-014 busy  output  1  high in RUN and DONE.
REQ-015 done  output  1  one-cycle pulse after the final beat transfers.

Function
REQ-016 FSM states IDLE, RUN, DONE; IDLE->RUN on start if every latched bound is nonzero; IDLE->DONE on start if any bound is 0 (zero beats emitted); RUN->DONE on transfer of the final beat; DONE->IDLE unconditionally after one cycle.
REQ-017 Beat transfer = out_valid AND out_ready in the same cycle.
REQ-018 out_valid is 1 in every RUN cycle and 0 in IDLE and DONE; the first beat (all idx=0, addr=base) is presented in the cycle after start is accepted.
REQ-019 While out_valid=1 and out_ready=0, addr and idx hold stable.
REQ-020 On transfer: idx[0] increments; any idx[j] equal to bound[j]-1 wraps to 0 and carries into idx[j+1]; idx[k] for k above the first non-wrapping dimension is unchanged.
REQ-021 Per-dimension offset off[j] tracks idx[j]*stride[j]: increments by stride[j] on increment, clears on wrap.
REQ-022 addr = base + sum of off[0..NDIM-1], computed modulo 2^ADDR_W (silent wrap, no overflow flag).
REQ-023 The final beat is the beat with idx[j]=bound[j]-1 for all j; total beats = product of bounds.
REQ-024 done=1 exactly in the DONE cycle, otherwise 0.
REQ-025 start is ignored in RUN and DONE; inputs base/bound/stride changing during RUN have no effect.
REQ-026 bound[j]=1 is legal: dimension j stays 0 and always carries.

Reset
REQ-027 reset has priority over all other inputs in the same cycle, including mid-sweep.
REQ-028 On reset: state=IDLE; out_valid=0, busy=0, done=0, idx all 0, off all 0, addr=0 (latched base cleared); the sweep is abandoned with no done pulse.

Configuration
REQ-029 Macro NESTED_COUNTER_LAST_EN defined: adds output last (NDIM bits), last[j]=1 when out_valid=1 and idx[i]=bound[i]-1 for all i<=j; last resets to 0.
REQ-030 NESTED_COUNTER_LAST_EN undefined: the last port does not exist; all other behaviour is identical.

Verification
REQ-031 NDIM=2, bound={3,2}, stride={1,16}, base=0x100, out_ready=1 -> addr sequence 0x100,0x101,0x102,0x110,0x111,0x112, then done pulse one cycle after the sixth beat.
REQ-032 Same config, out_ready toggled 1,0,0,1,... -> addr/idx stable during every stall cycle, no beat skipped or repeated, 6 beats total.
REQ-033 bound={0,5} start -> out_valid never asserted, busy=1 for one cycle, done pulse, return to IDLE.
REQ-034 base=0xFFFE, bound={4,1}, stride={1,0} -> addr 0xFFFE,0xFFFF,0x0000,0x0001 (modulo wrap).
REQ-035 reset asserted during the third beat of REQ-031 -> next cycle out_valid=0, busy=0, done=0, idx=0; new start reproduces the full REQ-031 sequence.
REQ-036 With NESTED_COUNTER_LAST_EN, REQ-031 stimulus -> last[0]=1 on beats 3 and 6, last[1]=1 on beat 6 only.

Source files
------------

// File: rtl/nested_counter.sv
// rtl/nested_counter.sv - NDIM-deep nested loop address generator; optional per-dimension last flags with NESTED_COUNTER_LAST_EN
module nested_counter #(
  parameter int NDIM   = 2,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic [ADDR_W-1:0]              base,
  input  logic [NDIM-1:0][WIDTH-1:0]     bound,
  input  logic [NDIM-1:0][ADDR_W-1:0]    stride,
  input  logic                           out_ready,
  output logic                           out_valid,
  output logic [ADDR_W-1:0]              addr,
  output logic [NDIM-1:0][WIDTH-1:0]     idx,
  output logic                           busy,
  output logic                           done
`ifdef NESTED_COUNTER_LAST_EN
  ,
  output logic [NDIM-1:0]                last
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]                     state;
  logic [ADDR_W-1:0]              base_q;
  logic [NDIM-1:0][WIDTH-1:0]     bound_q;
  logic [NDIM-1:0][ADDR_W-1:0]    stride_q;
  logic [NDIM-1:0][ADDR_W-1:0]    off_q;
  logic [NDIM-1:0][WIDTH-1:0]     idx_nxt;
  logic [NDIM-1:0][ADDR_W-1:0]    off_nxt;
  logic                           carry;
  logic                           any_zero;
  logic                           xfer;

  assign out_valid = (state == RUN);
  assign busy      = (state == RUN) || (state == DONE);
  assign done      = (state == DONE);
  assign xfer      = out_valid && out_ready;

  // A sweep with any empty dimension produces no beats at all
  always_comb begin
    any_zero = 1'b0;
    for (int j = 0; j < NDIM; j++) begin
      if (bound[j] == '0) any_zero = 1'b1;
    end
  end

  // Ripple-carry odometer step; carry surviving past the top dimension marks the final beat
  always_comb begin
    carry   = 1'b1;
    idx_nxt = idx;
    off_nxt = off_q;
    for (int j = 0; j < NDIM; j++) begin
      if (carry) begin
        if (idx[j] == bound_q[j] - WIDTH'(1)) begin
          idx_nxt[j] = '0;
          off_nxt[j] = '0;
        end else begin
          idx_nxt[j] = idx[j] + WIDTH'(1);
          off_nxt[j] = off_q[j] + stride_q[j];
          carry      = 1'b0;
        end
      end
    end
  end

  // Address is base plus per-dimension offsets, wrapping silently modulo 2^ADDR_W
  always_comb begin
    addr = base_q;
    for (int j = 0; j < NDIM; j++) begin
      addr = addr + off_q[j];
    end
  end

  // Sequencer: latch the job on start, advance on each transfer, one DONE cycle at the end
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      base_q   <= '0;
      bound_q  <= '0;
      stride_q <= '0;
      idx      <= '0;
      off_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            base_q   <= base;
            bound_q  <= bound;
            stride_q <= stride;
            idx      <= '0;
            off_q    <= '0;
            state    <= any_zero ? DONE : RUN;
          end
        end
        RUN: begin
          if (xfer) begin
            idx   <= idx_nxt;
            off_q <= off_nxt;
            if (carry) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef NESTED_COUNTER_LAST_EN
  logic run_last;

  // last[j] flags that dimensions 0..j are all at their final index on a valid beat
  always_comb begin
    run_last = out_valid;
    last     = '0;
    for (int j = 0; j < NDIM; j++) begin
      run_last = run_last && (idx[j] == bound_q[j] - WIDTH'(1));
      last[j]  = run_last;
    end
  end
`endif

endmodule

// File: tb/tb_nested_counter.sv
// tb/tb_nested_counter.sv - table-driven bench for nested_counter (NDIM=2, WIDTH=8, ADDR_W=16)
module tb_nested_counter;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [15:0]       base = '0;
  logic [1:0][7:0]   bound = '0;
  logic [1:0][15:0]  stride = '0;
  logic              out_ready = 1'b0;
  logic              out_valid;
  logic [15:0]       addr;
  logic [1:0][7:0]   idx;
  logic              busy;
  logic              done;
`ifdef NESTED_COUNTER_LAST_EN
  logic [1:0]        last;
`endif

  nested_counter #(.NDIM(2), .WIDTH(8), .ADDR_W(16)) dut (
    .clock(clock), .reset(reset), .start(start), .base(base), .bound(bound),
    .stride(stride), .out_ready(out_ready), .out_valid(out_valid), .addr(addr),
    .idx(idx), .busy(busy), .done(done)
`ifdef NESTED_COUNTER_LAST_EN
    , .last(last)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst, st, rdy;
    logic [15:0] cbase;
    logic [7:0]  b0, b1;
    logic [15:0] s0, s1;
    logic        chk, v, bz, dn, ca;
    logic [15:0] a;
    logic [7:0]  i0, i1;
    logic [1:0]  lst;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] cfg_base;
  logic [7:0]  cfg_b0, cfg_b1;
  logic [15:0] cfg_s0, cfg_s1;
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic set_cfg(input logic [15:0] bs, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [15:0] s0, input logic [15:0] s1);
    cfg_base = bs; cfg_b0 = b0; cfg_b1 = b1; cfg_s0 = s0; cfg_s1 = s1;
  endtask

  task automatic add(input logic rst, input logic st, input logic rdy, input logic chk,
                     input logic v, input logic bz, input logic dn, input logic ca,
                     input logic [15:0] a, input logic [7:0] i0, input logic [7:0] i1,
                     input logic [1:0] lst);
    vec_t r;
    r.rst = rst; r.st = st; r.rdy = rdy; r.cbase = cfg_base; r.b0 = cfg_b0; r.b1 = cfg_b1;
    r.s0 = cfg_s0; r.s1 = cfg_s1; r.chk = chk; r.v = v; r.bz = bz; r.dn = dn; r.ca = ca;
    r.a = a; r.i0 = i0; r.i1 = i1; r.lst = lst;
    vecs.push_back(r);
  endtask

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  logic [15:0] got[$];
  logic [15:0] exp_seq[6];
  bit          seen_done;

  initial begin
    exp_seq[0] = 16'h100; exp_seq[1] = 16'h101; exp_seq[2] = 16'h102;
    exp_seq[3] = 16'h110; exp_seq[4] = 16'h111; exp_seq[5] = 16'h112;

    // reset state and reset-over-start priority
    set_cfg(16'h100, 8'd3, 8'd2, 16'd1, 16'd16);
    add(1,0,1, 0, 0,0,0, 0,16'h0,   0,0, 2'b00);
    add(1,1,1, 1, 0,0,0, 1,16'h0,   0,0, 2'b00);
    add(0,0,1, 1, 0,0,0, 1,16'h0,   0,0, 2'b00);
    // plain 3x2 sweep, always ready
    add(0,1,1, 1, 0,0,0, 1,16'h0,   0,0, 2'b00);
    add(0,0,1, 1, 1,1,0, 1,16'h100, 0,0, 2'b00);
    add(0,0,1, 1, 1,1,0, 1,16'h101, 1,0, 2'b00);
    add(0,0,1, 1, 1,1,0, 1,16'h102, 2,0, 2'b01);
    add(0,0,1, 1, 1,1,0, 1,16'h110, 0,1, 2'b00);
    add(0,0,1, 1, 1,1,0, 1,16'h111, 1,1, 2'b00);
    add(0,0,1, 1, 1,1,0, 1,16'h112, 2,1, 2'b11);
    add(0,0,1, 1, 0,1,1, 0,16'h0,   0,0, 2'b00);
    add(0,0,1, 1, 0,0,0, 0,16'h0,   0,0, 2'b00);
    // stalled sweep, ready 1,0,0,1...; start and config churn while busy must be ignored
    add(0,1,0, 1, 0,0,0, 0,16'h0,   0,0, 2'b00);
    set_cfg(16'hDEAD, 8'd7, 8'd7, 16'd5, 16'd5);
    add(0,1,1, 1, 1,1,0, 1,16'h100, 0,0, 2'b00);
    add(0,1,0, 1, 1,1,0, 1,16'h101, 1,0, 2'b00);
    add(0,1,0, 1, 1,1,0, 1,16'h101, 1,0, 2'b00);
    add(0,1,1, 1, 1,1,0, 1,16'h101, 1,0, 2'b00);
    add(0,1,0, 1, 1,1,0, 1,16'h102, 2,0, 2'b01);
    add(0,1,0, 1, 1,1,0, 1,16'h102, 2,0, 2'b01);
    add(0,1,1, 1, 1,1,0, 1,16'h102, 2,0, 2'b01);
    add(0,1,0, 1, 1,1,0, 1,16'h110, 0,1, 2'b00);
    add(0,1,0, 1, 1,1,0, 1,16'h110, 0,1, 2'b00);
    add(0,1,1, 1, 1,1,0, 1,16'h110, 0,1, 2'b00);
    add(0,1,0, 1, 1,1,0, 1,16'h111, 1,1, 2'b00);
    add(0,1,0, 1, 1,1,0, 1,16'h111, 1,1, 2'b00);
    add(0,1,1, 1, 1,1,0, 1,16'h111, 1,1, 2'b00);
    add(0,1,0, 1, 1,1,0, 1,16'h112, 2,1, 2'b11);
    add(0,1,0, 1, 1,1,0, 1,16'h112, 2,1, 2'b11);
    add(0,1,1, 1, 1,1,0, 1,16'h112, 2,1, 2'b11);
    add(0,1,1, 1, 0,1,1, 0,16'h0,   0,0, 2'b00);
    add(0,0,1, 1, 0,0,0, 0,16'h0,   0,0, 2'b00);
    // zero bound: no beats, single busy+done cycle
    set_cfg(16'h100, 8'd0, 8'd5, 16'd1, 16'd16);
    add(0,1,1, 1, 0,0,0, 0,16'h0,   0,0, 2'b00);
    add(0,0,1, 1, 0,1,1, 0,16'h0,   0,0, 2'b00);
    add(0,0,1, 1, 0,0,0, 0,16'h0,   0,0, 2'b00);
    // address wrap with a bound=1 outer dimension
    set_cfg(16'hFFFE, 8'd4, 8'd1, 16'd1, 16'd0);
    add(0,1,1, 1, 0,0,0, 0,16'h0,   0,0, 2'b00);
    add(0,0,1, 1, 1,1,0, 1,16'hFFFE,0,0, 2'b00);
    add(0,0,1, 1, 1,1,0, 1,16'hFFFF,1,0, 2'b00);
    add(0,0,1, 1, 1,1,0, 1,16'h0000,2,0, 2'b00);
    add(0,0,1, 1, 1,1,0, 1,16'h0001,3,0, 2'b11);
    add(0,0,1, 1, 0,1,1, 0,16'h0,   0,0, 2'b00);
    add(0,0,1, 1, 0,0,0, 0,16'h0,   0,0, 2'b00);
    // reset during the third beat abandons the sweep without a done pulse
    set_cfg(16'h100, 8'd3, 8'd2, 16'd1, 16'd16);
    add(0,1,1, 1, 0,0,0, 0,16'h0,   0,0, 2'b00);
    add(0,0,1, 1, 1,1,0, 1,16'h100, 0,0, 2'b00);
    add(0,0,1, 1, 1,1,0, 1,16'h101, 1,0, 2'b00);
    add(1,0,1, 1, 1,1,0, 1,16'h102, 2,0, 2'b01);
    add(0,0,1, 1, 0,0,0, 1,16'h0,   0,0, 2'b00);
    add(0,0,1, 1, 0,0,0, 1,16'h0,   0,0, 2'b00);

    #1;
    foreach (vecs[i]) begin
      reset = vecs[i].rst; start = vecs[i].st; out_ready = vecs[i].rdy;
      base = vecs[i].cbase; bound[0] = vecs[i].b0; bound[1] = vecs[i].b1;
      stride[0] = vecs[i].s0; stride[1] = vecs[i].s1;
      if (vecs[i].chk) begin
        check($sformatf("row%0d out_valid", i), out_valid, vecs[i].v);
        check($sformatf("row%0d busy", i), busy, vecs[i].bz);
        check($sformatf("row%0d done", i), done, vecs[i].dn);
        if (vecs[i].v || vecs[i].ca) begin
          check($sformatf("row%0d addr", i), addr, vecs[i].a);
          check($sformatf("row%0d idx0", i), idx[0], vecs[i].i0);
          check($sformatf("row%0d idx1", i), idx[1], vecs[i].i1);
        end
`ifdef NESTED_COUNTER_LAST_EN
        check($sformatf("row%0d last", i), last, vecs[i].lst);
`endif
      end
      @(posedge clock); #1;
    end

    // restart after the abandoned sweep reproduces the full address sequence
    reset = 1'b0; out_ready = 1'b1; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    seen_done = 1'b0;
    for (int c = 0; c < 40 && !seen_done; c++) begin
      if (out_valid && out_ready) got.push_back(addr);
      if (done) seen_done = 1'b1;
      else begin
        @(posedge clock); #1;
      end
    end
    check("restart done seen", seen_done, 1);
    check("restart beat count", got.size(), 6);
    for (int k = 0; k < 6; k++) begin
      if (k < got.size()) check($sformatf("restart addr%0d", k), got[k], exp_seq[k]);
      else check($sformatf("restart addr%0d missing", k), 0, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
